// File: rtl/spi_clk_gen_pkg.sv
// spi_clk_gen_pkg
//  Shared definitions for the SPI serial-clock generator and the shift engine
//  that consumes its strobes: default widths and the generator state encoding.
//  Optional feature macro used by the files importing this package:
//  SPI_CLK_BURST_EN (burst length counter with done strobe).
package spi_clk_gen_pkg;

  localparam int CNT_W_DEF = 8;   // div / half-period counter width
  localparam int LEN_W_DEF = 16;  // burst_len width

  // STOP is RUN with a stop pending: the active half-period is being finished.
  typedef enum logic [1:0] {
    SCLK_IDLE = 2'd0,
    SCLK_RUN  = 2'd1,
    SCLK_STOP = 2'd2
  } sclk_state_e;

endpackage

// File: rtl/spi_clk_gen_if.sv
// spi_clk_gen_if
//  Control/status bundle between the SPI controller (master modport) and the
//  serial-clock generator (slave modport).
//  Signals: en, div, cpol (requests); sclk_out, lead_pulse, trail_pulse, busy,
//  state (generator status, state is a debug view of the FSM).
//  With SPI_CLK_BURST_EN defined: burst_len (request) and done (status).
//
//  Handshake: en is a level request, not a valid/ready pair. The generator
//  accepts it only in IDLE (busy=0); busy rises the next cycle and stays high
//  until the generator is back in IDLE. Dropping en requests a stop, which
//  always completes (re-raising en cannot cancel it); a new run needs busy=0
//  and en=1 again. div, cpol and burst_len are captured at acceptance.
interface spi_clk_gen_if import spi_clk_gen_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
`ifdef SPI_CLK_BURST_EN
  , parameter int LEN_W = LEN_W_DEF
`endif
);

  logic             en;
  logic [CNT_W-1:0] div;
  logic             cpol;
  logic             sclk_out;
  logic             lead_pulse;
  logic             trail_pulse;
  logic             busy;
  sclk_state_e      state;
`ifdef SPI_CLK_BURST_EN
  logic [LEN_W-1:0] burst_len;
  logic             done;

  modport master (output en, div, cpol, burst_len,
                  input  sclk_out, lead_pulse, trail_pulse, busy, state, done);
  modport slave  (input  en, div, cpol, burst_len,
                  output sclk_out, lead_pulse, trail_pulse, busy, state, done);
`else
  modport master (output en, div, cpol,
                  input  sclk_out, lead_pulse, trail_pulse, busy, state);
  modport slave  (input  en, div, cpol,
                  output sclk_out, lead_pulse, trail_pulse, busy, state);
`endif

endinterface

// File: rtl/spi_clk_gen_burst_cnt.sv
// spi_clk_gen_burst_cnt
//  Trailing-edge counter for burst mode (exists only with SPI_CLK_BURST_EN).
//  Ports: clk_in, rst (async, active-high), clr (zero the count), inc (one
//  trailing edge happens this cycle), limit (burst length, 0 = unlimited),
//  last (the next counted edge is the final one of the burst).
`ifdef SPI_CLK_BURST_EN
module spi_clk_gen_burst_cnt #(
  parameter int LEN_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] limit,
  output logic             last
);

  logic [LEN_W-1:0] count_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Looks one edge ahead so the FSM can leave RUN on the terminal edge itself.
  assign last = (limit != '0) && (count_q == limit - 1'b1);

endmodule
`endif

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
//  Programmable SPI serial-clock generator: runtime half-period divisor, CPOL
//  idle level, glitch-free start/stop, one-cycle strobes on leading and
//  trailing SCLK edges. All outputs are registered; a strobe is high in the
//  same cycle sclk_out first shows the new level.
//  Ports: clk_in, rst (async, active-high), bus (spi_clk_gen_if.slave).
//  Optional macro SPI_CLK_BURST_EN: adds burst_len/done and a trailing-edge
//  counter that ends the run after burst_len SCLK cycles (0 = unlimited).
module spi_clk_gen import spi_clk_gen_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
`ifdef SPI_CLK_BURST_EN
  , parameter int LEN_W = LEN_W_DEF
`endif
) (
  input  logic          clk_in,
  input  logic          rst,
  spi_clk_gen_if.slave  bus
);

  sclk_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q;
  logic             cpol_q;
  logic             sclk_q, sclk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;
  logic             at_idle;
  logic             half_done;
  logic             burst_stop;

`ifdef SPI_CLK_BURST_EN
  logic [LEN_W-1:0] burst_len_q;
  logic             burst_clr;
  logic             burst_inc;
  logic             burst_last;

  spi_clk_gen_burst_cnt #(.LEN_W(LEN_W)) u_burst_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (burst_clr),
    .inc    (burst_inc),
    .limit  (burst_len_q),
    .last   (burst_last)
  );

  assign burst_stop = burst_last;
  assign bus.done   = done_q;
`else
  assign burst_stop = 1'b0;
`endif

  assign at_idle   = (sclk_q == cpol_q);
  assign half_done = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef SPI_CLK_BURST_EN
    burst_clr = 1'b0;
    burst_inc = 1'b0;
`endif
    case (state_q)
      SCLK_IDLE: begin
        sclk_d = bus.cpol;
        cnt_d  = '0;
        busy_d = bus.en;
        if (bus.en) begin
          state_d = SCLK_RUN;
          load    = 1'b1;
`ifdef SPI_CLK_BURST_EN
          burst_clr = 1'b1;
`endif
        end
      end
      SCLK_RUN, SCLK_STOP: begin
        if ((state_q == SCLK_RUN) && !bus.en && at_idle) begin
          // Stop while at idle level: leave at once, no edge.
          state_d = SCLK_IDLE;
          cnt_d   = '0;
        end else if (half_done) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (at_idle) begin
            lead_d = 1'b1;
          end else begin
            trail_d = 1'b1;
`ifdef SPI_CLK_BURST_EN
            burst_inc = 1'b1;
`endif
            if ((state_q == SCLK_STOP) || !bus.en) begin
              state_d = SCLK_IDLE;
            end
            if (burst_stop) begin
              state_d = SCLK_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Active level here: finish the half-period before stopping.
          if (!bus.en) begin
            state_d = SCLK_STOP;
          end
        end
      end
      default: begin
        state_d = SCLK_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= SCLK_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      sclk_q      <= 1'b0;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SPI_CLK_BURST_EN
      burst_len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        div_q       <= bus.div;
        cpol_q      <= bus.cpol;
`ifdef SPI_CLK_BURST_EN
        burst_len_q <= bus.burst_len;
`endif
      end
    end
  end

  assign bus.sclk_out    = sclk_q;
  assign bus.lead_pulse  = lead_q;
  assign bus.trail_pulse = trail_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;

`ifndef SPI_CLK_BURST_EN
  // done_q only feeds the burst port; keep it observable-free but consumed.
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_spi_clk_gen.sv
// tb_spi_clk_gen
//  Self-checking bench for spi_clk_gen. Expected SCLK edges are derived from
//  the start cycle, divisor and stop cycle, pushed into exp_q when stimulus is
//  applied, and popped as the generator produces lead/trail strobes.
//  Build with SPI_CLK_BURST_EN defined to include the burst scenario.
module tb_spi_clk_gen import spi_clk_gen_pkg::*;;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  spi_clk_gen_if #(.CNT_W(8)) bus ();

  spi_clk_gen #(.CNT_W(8)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  // clock / reset
  initial forever #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Edge k of a run started at posedge s is at s+(k+1)*(d+1); even k lead.
  // en=0 is sampled at posedge p: earlier edges happen, an edge at or after p
  // happens only if it is a trailing one. Returns the cycle busy reads 0.
  function automatic int push_edges(int s, int d, int p);
    int t;
    int fall;
    logic [31:0] ev;
    fall = p + 1;
    for (int k = 0; k < 1000; k++) begin
      t = s + (k + 1) * (d + 1);
      if (t < p) begin
        ev = {(k % 2 == 0), t[30:0]};
        exp_q.push_back(ev);
      end else begin
        if (k % 2 == 1) begin
          ev = {1'b0, t[30:0]};
          exp_q.push_back(ev);
          fall = t + 1;
        end
        break;
      end
    end
    return fall;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.cpol = 1'b1;
    bus.div = 8'd0;
`ifdef SPI_CLK_BURST_EN
    bus.burst_len = '0;
`endif
    repeat (3) @(negedge clk_in);
    checks++; if (bus.sclk_out !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", bus.sclk_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.lead_pulse, bus.trail_pulse} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {bus.lead_pulse, bus.trail_pulse}); end
    checks++; if (bus.state !== SCLK_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", bus.state, SCLK_IDLE); end
`ifdef SPI_CLK_BURST_EN
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
`endif
    rst = 1'b0;
    @(negedge clk_in);
    checks++; if (bus.sclk_out !== 1'b1) begin errors++; $display("FAIL idle_cpol: got %b want 1", bus.sclk_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_div3();
    int s, p, fall;
    logic [31:0] e, obs;
    bus.div = 8'd3;
    bus.cpol = 1'b0;
    @(negedge clk_in);
    bus.en = 1'b1;
    s = cyc + 1;
    p = s + 40;
    fall = push_edges(s, 3, p);
    for (int i = 0; i < 55; i++) begin
      @(negedge clk_in);
      if (bus.lead_pulse || bus.trail_pulse) begin
        checks++;
        obs = {bus.lead_pulse, cyc[30:0]};
        if (exp_q.size() == 0) begin errors++; $display("FAIL div3_edge: got lead=%b at cycle %0d want no edge", bus.lead_pulse, cyc - s); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL div3_edge: got lead=%b at %0d want lead=%b at %0d", obs[31], obs[30:0] - s, e[31], e[30:0] - s); end
        end
        checks++;
        if (bus.sclk_out !== bus.lead_pulse) begin errors++; $display("FAIL div3_level: got sclk=%b want %b", bus.sclk_out, bus.lead_pulse); end
      end
      if (cyc == fall - 1) begin checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div3_busy_hold: got %b want 1", bus.busy); end end
      if (cyc == fall) begin checks++; if ({bus.busy, bus.sclk_out} !== 2'b00) begin errors++; $display("FAIL div3_end: got busy,sclk=%b want 00", {bus.busy, bus.sclk_out}); end end
      if (cyc == p - 1) bus.en = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL div3_missing: got %0d edges left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_div0_cpol1();
    int s, p, fall;
    logic [31:0] e, obs;
    bus.div = 8'd0;
    bus.cpol = 1'b1;
    @(negedge clk_in);
    bus.en = 1'b1;
    s = cyc + 1;
    p = s + 8;
    fall = push_edges(s, 0, p);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (bus.lead_pulse || bus.trail_pulse) begin
        checks++;
        obs = {bus.lead_pulse, cyc[30:0]};
        if (exp_q.size() == 0) begin errors++; $display("FAIL div0_edge: got lead=%b at cycle %0d want no edge", bus.lead_pulse, cyc - s); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL div0_edge: got lead=%b at %0d want lead=%b at %0d", obs[31], obs[30:0] - s, e[31], e[30:0] - s); end
        end
        checks++;
        if (bus.sclk_out !== ~bus.lead_pulse) begin errors++; $display("FAIL div0_level: got sclk=%b want %b", bus.sclk_out, ~bus.lead_pulse); end
      end
      if (cyc == p - 1) begin
        checks++; if (bus.sclk_out !== 1'b0) begin errors++; $display("FAIL div0_active: got sclk=%b want 0", bus.sclk_out); end
        bus.en = 1'b0;
      end
      if (cyc == fall - 1) begin checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div0_busy_hold: got %b want 1", bus.busy); end end
      if (cyc == fall) begin checks++; if ({bus.busy, bus.sclk_out} !== 2'b01) begin errors++; $display("FAIL div0_end: got busy,sclk=%b want 01", {bus.busy, bus.sclk_out}); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL div0_missing: got %0d edges left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stop_div2();
    int s, p, fall;
    logic [31:0] e, obs;
    bus.div = 8'd2;
    bus.cpol = 1'b0;
    @(negedge clk_in);
    bus.en = 1'b1;
    s = cyc + 1;
    p = s + 11;  // en drops one cycle after the lead strobe at s+9
    fall = push_edges(s, 2, p);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_in);
      if (bus.lead_pulse || bus.trail_pulse) begin
        checks++;
        obs = {bus.lead_pulse, cyc[30:0]};
        if (exp_q.size() == 0) begin errors++; $display("FAIL stop_edge: got lead=%b at cycle %0d want no edge", bus.lead_pulse, cyc - s); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL stop_edge: got lead=%b at %0d want lead=%b at %0d", obs[31], obs[30:0] - s, e[31], e[30:0] - s); end
        end
      end
      if (cyc == s + 4) bus.div = 8'd7;          // ignored until the next start
      if (cyc == p - 1) bus.en = 1'b0;
      if (cyc == p) bus.en = 1'b1;               // must not cancel the stop
      if (cyc == p + 1) bus.en = 1'b0;
      if (cyc == fall) begin checks++; if ({bus.busy, bus.sclk_out} !== 2'b00) begin errors++; $display("FAIL stop_end: got busy,sclk=%b want 00", {bus.busy, bus.sclk_out}); end end
      if (cyc == fall + 4) begin checks++; if ({bus.busy, bus.sclk_out} !== 2'b00) begin errors++; $display("FAIL stop_idle: got busy,sclk=%b want 00", {bus.busy, bus.sclk_out}); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_missing: got %0d edges left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int s;
    bus.div = 8'd3;
    bus.cpol = 1'b1;
    @(negedge clk_in);
    bus.en = 1'b1;
    s = cyc + 1;
    while (cyc < s + 4) @(negedge clk_in);
    checks++; if ({bus.lead_pulse, bus.sclk_out} !== 2'b10) begin errors++; $display("FAIL arst_pre: got lead,sclk=%b want 10", {bus.lead_pulse, bus.sclk_out}); end
    #2;
    rst = 1'b1;
    bus.en = 1'b0;
    #1;
    checks++; if ({bus.sclk_out, bus.lead_pulse, bus.trail_pulse, bus.busy} !== 4'b0000) begin errors++; $display("FAIL arst_now: got sclk,lead,trail,busy=%b want 0000", {bus.sclk_out, bus.lead_pulse, bus.trail_pulse, bus.busy}); end
    checks++; if (bus.state !== SCLK_IDLE) begin errors++; $display("FAIL arst_state: got %0d want %0d", bus.state, SCLK_IDLE); end
    @(negedge clk_in);
    checks++; if (bus.sclk_out !== 1'b0) begin errors++; $display("FAIL arst_hold: got sclk=%b want 0", bus.sclk_out); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      checks++;
      if ({bus.sclk_out, bus.lead_pulse, bus.trail_pulse, bus.busy} !== 4'b1000) begin
        errors++; $display("FAIL arst_after: cycle %0d got sclk,lead,trail,busy=%b want 1000", i, {bus.sclk_out, bus.lead_pulse, bus.trail_pulse, bus.busy});
      end
    end
  endtask

`ifdef SPI_CLK_BURST_EN
  task automatic test_burst();
    int s, fall, t;
    logic [31:0] e, obs;
    bus.div = 8'd1;
    bus.cpol = 1'b0;
    bus.burst_len = 16'd8;
    @(negedge clk_in);
    bus.en = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 16; k++) begin
      t = s + 2 * (k + 1);
      e = {(k % 2 == 0), t[30:0]};
      exp_q.push_back(e);
    end
    fall = s + 33;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_in);
      if (bus.lead_pulse || bus.trail_pulse) begin
        checks++;
        obs = {bus.lead_pulse, cyc[30:0]};
        if (exp_q.size() == 0) begin errors++; $display("FAIL burst_edge: got lead=%b at cycle %0d want no edge", bus.lead_pulse, cyc - s); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL burst_edge: got lead=%b at %0d want lead=%b at %0d", obs[31], obs[30:0] - s, e[31], e[30:0] - s); end
        end
      end
      if (bus.done && cyc != s + 32) begin checks++; errors++; $display("FAIL burst_done_stray: got done at cycle %0d want only at 32", cyc - s); end
      if (cyc == s + 32) begin
        checks++; if ({bus.done, bus.trail_pulse} !== 2'b11) begin errors++; $display("FAIL burst_done: got done,trail=%b want 11", {bus.done, bus.trail_pulse}); end
        bus.en = 1'b0;
      end
      if (cyc == fall - 1) begin checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy_hold: got %b want 1", bus.busy); end end
      if (cyc == fall) begin checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL burst_busy_fall: got %b want 0", bus.busy); end end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing: got %0d edges left want 0", exp_q.size()); end
    exp_q.delete();
    bus.burst_len = '0;
  endtask
`endif

  initial begin
    bus.en = 1'b0;
    bus.div = 8'd0;
    bus.cpol = 1'b0;
`ifdef SPI_CLK_BURST_EN
    bus.burst_len = '0;
`endif
    test_reset();
    test_div3();
    test_div0_cpol1();
    test_stop_div2();
    test_async_reset();
`ifdef SPI_CLK_BURST_EN
    test_burst();
`endif
    repeat (2) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
